// File: rtl/ss_mbuf.sv
// Multi-slot clock-crossing buffer: each slot carries a write toggle and a read toggle,
// and each side learns the other side's progress through a toggle resynchroniser.
module ss_mbuf #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int SYNC_W  = 2,
   parameter int PROT_WR = 1,
   parameter int PROT_RD = 1,
   parameter int REG_OUT = 1,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic              rst_i,
   input  logic              wr_clk_i,
   input  logic              rd_clk_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_i,
   output logic              wr_rdy_o,
   output logic [CW-1:0]     wr_free_o,
   output logic              wr_err_o,
   input  logic              wr_err_clr_i,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              rd_i,
   output logic              rd_rdy_o,
   output logic [CW-1:0]     rd_avail_o,
   output logic              rd_err_o,
   input  logic              rd_err_clr_i
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0]  wr_tog_reg;
   logic [DEPTH-1:0]  rd_tog_reg;
   logic [DEPTH-1:0]  wr_tog_sync;
   logic [DEPTH-1:0]  rd_tog_sync;
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [DATA_W-1:0] slot_reg [DEPTH];
   logic              wr_err_reg;
   logic              rd_err_reg;

   logic [DEPTH-1:0]  slot_free;
   logic [DEPTH-1:0]  slot_full;
   logic [DEPTH-1:0]  wr_sel;
   logic [DEPTH-1:0]  rd_sel;
   logic              wr_rdy;
   logic              rd_rdy;
   logic              wr_en;
   logic              rd_en;
   logic [CW-1:0]     wr_free;
   logic [CW-1:0]     rd_avail;

   generate
      if (SYNC_W > 0) begin : g_sync
         logic [DEPTH-1:0] w2r_reg [SYNC_W];
         logic [DEPTH-1:0] r2w_reg [SYNC_W];

         always_ff @(posedge rd_clk_i or posedge rst_i) begin
            if (rst_i) begin
               for (int i = 0; i < SYNC_W; i++) w2r_reg[i] <= '0;
            end else begin
               w2r_reg[0] <= wr_tog_reg;
               for (int i = 1; i < SYNC_W; i++) w2r_reg[i] <= w2r_reg[i-1];
            end
         end

         always_ff @(posedge wr_clk_i or posedge rst_i) begin
            if (rst_i) begin
               for (int i = 0; i < SYNC_W; i++) r2w_reg[i] <= '0;
            end else begin
               r2w_reg[0] <= rd_tog_reg;
               for (int i = 1; i < SYNC_W; i++) r2w_reg[i] <= r2w_reg[i-1];
            end
         end

         assign wr_tog_sync = w2r_reg[SYNC_W-1];
         assign rd_tog_sync = r2w_reg[SYNC_W-1];
      end else begin : g_nosync
         assign wr_tog_sync = wr_tog_reg;
         assign rd_tog_sync = rd_tog_reg;
      end
   endgenerate

   // A slot is free on the write side once the reader has toggled it back into agreement.
   assign slot_free = ~(wr_tog_reg ^ rd_tog_sync);
   assign slot_full = rd_tog_reg ^ wr_tog_sync;
   assign wr_rdy    = slot_free[wr_ptr_reg];
   assign rd_rdy    = slot_full[rd_ptr_reg];

   assign wr_en  = wr_i && (wr_rdy || (PROT_WR == 0));
   assign rd_en  = rd_i && (rd_rdy || (PROT_RD == 0));
   assign wr_sel = DEPTH'(1) << wr_ptr_reg;
   assign rd_sel = DEPTH'(1) << rd_ptr_reg;

   always_comb begin
      wr_free  = '0;
      rd_avail = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_free  = wr_free + CW'(slot_free[i]);
         rd_avail = rd_avail + CW'(slot_full[i]);
      end
   end

   always_ff @(posedge wr_clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_tog_reg <= '0;
         wr_ptr_reg <= '0;
         wr_err_reg <= 1'b0;
         for (int i = 0; i < DEPTH; i++) slot_reg[i] <= '0;
      end else begin
         if (wr_en) begin
            wr_tog_reg <= wr_tog_reg ^ wr_sel;
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
            for (int i = 0; i < DEPTH; i++) begin
               if (wr_sel[i]) slot_reg[i] <= wr_data_i;
            end
         end
         if (wr_i && !wr_rdy) begin
            wr_err_reg <= 1'b1;
         end else if (wr_err_clr_i) begin
            wr_err_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge rd_clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_tog_reg <= '0;
         rd_ptr_reg <= '0;
         rd_err_reg <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_tog_reg <= rd_tog_reg ^ rd_sel;
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (rd_i && !rd_rdy) begin
            rd_err_reg <= 1'b1;
         end else if (rd_err_clr_i) begin
            rd_err_reg <= 1'b0;
         end
      end
   end

   // Slot contents are stable while a slot is full, so the read side may sample them directly.
   assign rd_data_o = slot_reg[rd_ptr_reg];
   assign wr_err_o  = wr_err_reg;
   assign rd_err_o  = rd_err_reg;

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic          wr_rdy_reg;
         logic [CW-1:0] wr_free_reg;
         logic          rd_rdy_reg;
         logic [CW-1:0] rd_avail_reg;

         always_ff @(posedge wr_clk_i or posedge rst_i) begin
            if (rst_i) begin
               wr_rdy_reg  <= 1'b0;
               wr_free_reg <= '0;
            end else begin
               wr_rdy_reg  <= wr_rdy;
               wr_free_reg <= wr_free;
            end
         end

         always_ff @(posedge rd_clk_i or posedge rst_i) begin
            if (rst_i) begin
               rd_rdy_reg   <= 1'b0;
               rd_avail_reg <= '0;
            end else begin
               rd_rdy_reg   <= rd_rdy;
               rd_avail_reg <= rd_avail;
            end
         end

         assign wr_rdy_o   = wr_rdy_reg;
         assign wr_free_o  = wr_free_reg;
         assign rd_rdy_o   = rd_rdy_reg;
         assign rd_avail_o = rd_avail_reg;
      end else begin : g_comb_out
         assign wr_rdy_o   = wr_rdy;
         assign wr_free_o  = wr_free;
         assign rd_rdy_o   = rd_rdy;
         assign rd_avail_o = rd_avail;
      end
   endgenerate

endmodule

// File: tb/tb_ss_mbuf.sv
// Directed bench for ss_mbuf: protected instance u0 plus an unprotected-write instance u1.
module tb_ss_mbuf;

   logic       wr_clk = 1'b0;
   logic       rd_clk = 1'b0;
   logic       rst    = 1'b0;

   logic [7:0] wr_data = 8'h00;
   logic       wr      = 1'b0;
   logic       wr_clr  = 1'b0;
   logic       rd      = 1'b0;
   logic       rd_clr  = 1'b0;
   logic       wr_rdy, wr_err, rd_rdy, rd_err;
   logic [2:0] wr_free, rd_avail;
   logic [7:0] rd_data;

   logic [7:0] w1_data = 8'h00;
   logic       w1_wr   = 1'b0;
   logic       w1_clr  = 1'b0;
   logic       r1_rd   = 1'b0;
   logic       r1_clr  = 1'b0;
   logic       w1_rdy, w1_err, r1_rdy, r1_err;
   logic [2:0] w1_free, r1_avail;
   logic [7:0] r1_data;

   int checks = 0;
   int errors = 0;
   int nrx    = 0;

   ss_mbuf #(.DATA_W(8), .DEPTH(4), .SYNC_W(2), .PROT_WR(1), .PROT_RD(1), .REG_OUT(1)) u0 (
      .rst_i(rst), .wr_clk_i(wr_clk), .rd_clk_i(rd_clk),
      .wr_data_i(wr_data), .wr_i(wr), .wr_rdy_o(wr_rdy), .wr_free_o(wr_free),
      .wr_err_o(wr_err), .wr_err_clr_i(wr_clr),
      .rd_data_o(rd_data), .rd_i(rd), .rd_rdy_o(rd_rdy), .rd_avail_o(rd_avail),
      .rd_err_o(rd_err), .rd_err_clr_i(rd_clr)
   );

   ss_mbuf #(.DATA_W(8), .DEPTH(4), .SYNC_W(2), .PROT_WR(0), .PROT_RD(1), .REG_OUT(1)) u1 (
      .rst_i(rst), .wr_clk_i(wr_clk), .rd_clk_i(rd_clk),
      .wr_data_i(w1_data), .wr_i(w1_wr), .wr_rdy_o(w1_rdy), .wr_free_o(w1_free),
      .wr_err_o(w1_err), .wr_err_clr_i(w1_clr),
      .rd_data_o(r1_data), .rd_i(r1_rd), .rd_rdy_o(r1_rdy), .rd_avail_o(r1_avail),
      .rd_err_o(r1_err), .rd_err_clr_i(r1_clr)
   );

   // Read clock runs 3x faster, offset so its edges never coincide with write-clock edges.
   always #15 wr_clk = ~wr_clk;
   initial begin
      #2;
      forever #5 rd_clk = ~rd_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr_rdy"},   32'(wr_rdy),   32'd0);
      chk({tag, "_wr_free"},  32'(wr_free),  32'd0);
      chk({tag, "_rd_rdy"},   32'(rd_rdy),   32'd0);
      chk({tag, "_rd_avail"}, 32'(rd_avail), 32'd0);
      chk({tag, "_rd_data"},  32'(rd_data),  32'd0);
      chk({tag, "_wr_err"},   32'(wr_err),   32'd0);
      chk({tag, "_rd_err"},   32'(rd_err),   32'd0);
   endtask

   task automatic do_wr(input logic [7:0] d);
      @(negedge wr_clk);
      wr_data = d;
      wr      = 1'b1;
      @(negedge wr_clk);
      wr      = 1'b0;
   endtask

   task automatic do_wr1(input logic [7:0] d);
      @(negedge wr_clk);
      w1_data = d;
      w1_wr   = 1'b1;
      @(negedge wr_clk);
      w1_wr   = 1'b0;
   endtask

   task automatic do_rd();
      @(negedge rd_clk);
      rd = 1'b1;
      @(negedge rd_clk);
      rd = 1'b0;
   endtask

   initial begin
      bit ok;

      // Power-on reset
      #1 rst = 1'b1;
      #5;
      chk_reset("por");
      @(negedge wr_clk);
      rst = 1'b0;
      @(negedge wr_clk);
      chk("rel_wr_rdy",  32'(wr_rdy),  32'd1);
      chk("rel_wr_free", 32'(wr_free), 32'd4);
      chk("rel_rd_rdy",  32'(rd_rdy),  32'd0);

      // Single transfer
      do_wr(8'hA5);
      @(negedge wr_clk);
      chk("single_wr_free", 32'(wr_free), 32'd3);
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge rd_clk);
         ok = rd_rdy;
      end
      chk("single_rd_rdy",   32'(ok),       32'd1);
      chk("single_rd_data",  32'(rd_data),  32'hA5);
      chk("single_rd_avail", 32'(rd_avail), 32'd1);
      do_rd();
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge wr_clk);
         ok = (wr_free == 3'd4);
      end
      chk("single_free_back", 32'(ok),       32'd1);
      chk("single_avail0",    32'(rd_avail), 32'd0);

      // Fill, overflow attempt, drain
      for (int k = 1; k <= 4; k++) do_wr(8'(k));
      @(negedge wr_clk);
      chk("full_wr_rdy",  32'(wr_rdy),  32'd0);
      chk("full_wr_free", 32'(wr_free), 32'd0);
      do_wr(8'hEE);
      chk("ovf_wr_err",  32'(wr_err),  32'd1);
      chk("ovf_wr_free", 32'(wr_free), 32'd0);
      @(negedge wr_clk);
      wr_clr = 1'b1;
      @(negedge wr_clk);
      wr_clr = 1'b0;
      chk("ovf_err_clr", 32'(wr_err), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge rd_clk);
         ok = (rd_avail == 3'd4);
      end
      chk("fill_avail4", 32'(ok), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge rd_clk);
         chk("drain_data", 32'(rd_data), 32'(k));
         rd = 1'b1;
         @(negedge rd_clk);
         rd = 1'b0;
      end
      repeat (3) @(negedge rd_clk);
      chk("drain_avail0", 32'(rd_avail), 32'd0);
      chk("drain_rd_rdy", 32'(rd_rdy),   32'd0);
      chk("drain_rd_err", 32'(rd_err),   32'd0);

      // Underflow; clear loses to a simultaneous set
      @(negedge rd_clk);
      rd = 1'b1;
      @(negedge rd_clk);
      chk("unf_rd_err", 32'(rd_err), 32'd1);
      rd_clr = 1'b1;
      @(negedge rd_clk);
      chk("unf_set_wins", 32'(rd_err), 32'd1);
      rd = 1'b0;
      @(negedge rd_clk);
      chk("unf_cleared", 32'(rd_err), 32'd0);
      rd_clr = 1'b0;
      // An unmoved read pointer sees the next write in its own slot
      do_wr(8'h5A);
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge rd_clk);
         ok = rd_rdy;
      end
      chk("unf_ptr_rdy",  32'(ok),      32'd1);
      chk("unf_ptr_data", 32'(rd_data), 32'h5A);
      do_rd();

      // Concurrent stream of 10 values through the wrapping pointers
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               int g;
               g = 0;
               do begin
                  @(negedge wr_clk);
                  g++;
               end while (!wr_rdy && g < 100);
               chk("stream_wr_rdy", 32'(wr_rdy), 32'd1);
               wr_data = 8'h30 + 8'(i);
               wr      = 1'b1;
               @(negedge wr_clk);
               wr      = 1'b0;
            end
         end
         begin
            for (int i = 0; i < 600 && nrx < 10; i++) begin
               @(negedge rd_clk);
               if (rd_rdy) begin
                  chk("stream_data", 32'(rd_data), 32'h30 + 32'(nrx));
                  nrx++;
                  rd = 1'b1;
                  @(negedge rd_clk);
                  rd = 1'b0;
               end
            end
         end
      join
      chk("stream_count",  32'(nrx),    32'd10);
      chk("stream_wr_err", 32'(wr_err), 32'd0);
      chk("stream_rd_err", 32'(rd_err), 32'd0);

      // Reset with two slots full
      do_wr(8'hC1);
      do_wr(8'hC2);
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge rd_clk);
         ok = (rd_avail == 3'd2);
      end
      chk("mid_avail2", 32'(ok), 32'd1);
      @(negedge wr_clk);
      rst = 1'b1;
      #1;
      chk_reset("mid");
      @(negedge wr_clk);
      rst = 1'b0;
      @(negedge wr_clk);
      chk("mid_rel_wr_rdy",  32'(wr_rdy),  32'd1);
      chk("mid_rel_wr_free", 32'(wr_free), 32'd4);
      repeat (3) @(negedge rd_clk);
      chk("mid_rel_avail", 32'(rd_avail), 32'd0);
      chk("mid_rel_rd_rdy", 32'(rd_rdy),  32'd0);

      // Unprotected write into a full buffer overwrites slot 0 and flips its state
      for (int k = 0; k < 4; k++) do_wr1(8'h11 + 8'(k));
      @(negedge wr_clk);
      chk("np_full_free", 32'(w1_free), 32'd0);
      do_wr1(8'h99);
      repeat (4) @(negedge wr_clk);
      chk("np_wr_err",   32'(w1_err),   32'd1);
      chk("np_wr_free",  32'(w1_free),  32'd1);
      chk("np_wr_rdy",   32'(w1_rdy),   32'd0);
      chk("np_rd_avail", 32'(r1_avail), 32'd3);
      chk("np_rd_rdy",   32'(r1_rdy),   32'd0);
      chk("np_rd_data",  32'(r1_data),  32'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ss_mbuf.md
SS_MBUF -- requirements
Module: ss_mbuf

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, data width in bits (1..64)
- DEPTH, 4, number of slots, power of 2 (2..16)
- SYNC_W, 2, resync register stages per crossing; 0 = synchronous/no resync
- PROT_WR, 1, 1 = write when not ready is ignored; 0 = no write protection
- PROT_RD, 1, 1 = read when not ready is ignored; 0 = no read protection
- REG_OUT, 1, 1 = register rdy/count outputs; 0 = combinational
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- rst_i, in, 1, reset, asynchronous, active-high
- wr_clk_i, in, 1, write clock
- rd_clk_i, in, 1, read clock
- wr_data_i, in, DATA_W, write data
- wr_i, in, 1, write strobe, active high
- wr_rdy_o, out, 1, current write slot free
- wr_free_o, out, CW = $clog2(DEPTH+1), free slots as seen by the write side
- wr_err_o, out, 1, sticky: write attempted while not ready
- wr_err_clr_i, in, 1, clears wr_err_o (wr_clk domain)
- rd_data_o, out, DATA_W, data at read pointer
- rd_i, in, 1, read strobe, active high
- rd_rdy_o, out, 1, current read slot full
- rd_avail_o, out, CW, full slots as seen by the read side
- rd_err_o, out, 1, sticky: read attempted while not ready
- rd_err_clr_i, in, 1, clears rd_err_o (rd_clk domain)

Function
REQ-003 Each slot i SHALL have a write toggle wst[i] (wr_clk domain), a read toggle rst_[i] (rd_clk domain) and a data register slot[i] (wr_clk domain).
REQ-004 Each toggle vector SHALL cross to the other domain through SYNC_W flops per bit; with SYNC_W=0 it SHALL be used directly.
REQ-005 Write side slot i free SHALL mean wst[i] == synced rst_[i]. Read side slot i full SHALL mean rst_[i] != synced wst[i].
REQ-006 Internal wr_rdy SHALL be "slot free" at wr_ptr; internal rd_rdy SHALL be "slot full" at rd_ptr.
REQ-007 wr_en SHALL be wr_i && wr_rdy when PROT_WR=1, else wr_i.
- On wr_en: slot[wr_ptr] <= wr_data_i; wst[wr_ptr] toggles; wr_ptr <= wr_ptr+1 mod DEPTH (natural wrap).
REQ-008 rd_en SHALL be rd_i && rd_rdy when PROT_RD=1, else rd_i.
- On rd_en: rst_[rd_ptr] toggles; rd_ptr <= rd_ptr+1 mod DEPTH.
REQ-009 rd_data_o SHALL be combinationally slot[rd_ptr]; it is valid whenever rd_rdy is high.
REQ-010 A slot register SHALL be written only at wr_en. With PROT_WR=1 a full slot is never overwritten.
REQ-011 wr_free_o SHALL be the popcount of free slots; rd_avail_o SHALL be the popcount of full slots.
REQ-012 With REG_OUT=1, wr_rdy_o/wr_free_o SHALL be registered on wr_clk_i and rd_rdy_o/rd_avail_o on rd_clk_i, adding one cycle of latency. With REG_OUT=0 they SHALL equal the internal values. Protection always uses the internal, unregistered ready.
REQ-013 Latency: after a write edge, internal rd_rdy for that slot SHALL rise after SYNC_W rd_clk edges (plus up to one more edge when asynchronous), then REG_OUT more. Free-slot return to the write side SHALL be symmetric.
REQ-014 wr_err_o SHALL set on any wr_clk edge with wr_i && !wr_rdy, independent of PROT_WR, and clear on wr_err_clr_i. Set SHALL win over a simultaneous clear. rd_err_o SHALL behave the same way on the read side.
REQ-015 Simultaneous write and read SHALL be legal on any slots, including the same slot index in different phases. Full (free=0) and empty (avail=0) SHALL be reached without error.
REQ-016 With PROT_*=0, an unready access SHALL still toggle state and advance the pointer (state corruption is permitted) and SHALL set the error flag.

Reset
REQ-017 rst_i SHALL asynchronously clear all toggles, pointers, sync flops, slot registers, error flags and registered outputs.
REQ-018 Reset values SHALL be:
- wr_rdy_o = 0 and wr_free_o = 0 when REG_OUT=1; otherwise 1 and DEPTH.
- rd_rdy_o = 0, rd_avail_o = 0, rd_data_o = 0, wr_err_o = 0, rd_err_o = 0.
REQ-019 Reset asserted mid-operation SHALL discard all contents. After release, wr_rdy_o = 1 and wr_free_o = DEPTH within 1 wr_clk edge (REG_OUT=1).

Verification (DATA_W=8, DEPTH=4, SYNC_W=2, REG_OUT=1, PROT=1 unless noted)
REQ-020 Single transfer: write 0xA5 -> rd_rdy_o high within 3-4 rd_clk edges, rd_data_o = 0xA5. Read it -> wr_free_o returns to 4.
REQ-021 Fill and drain: write 0x01..0x04 with no reads -> wr_rdy_o = 0, wr_free_o = 0. A 5th write is ignored and wr_err_o = 1. Drain -> data 0x01..0x04 in order, rd_avail_o = 0.
REQ-022 Wrap: stream 10 values with concurrent reads, rd_clk = 3 x wr_clk -> all values are received in order, no errors, and pointers wrap twice.
REQ-023 Underflow: rd_i asserted while empty -> rd_err_o = 1 and rd_ptr is unchanged. rd_err_clr_i asserted together with rd_i still unready -> rd_err_o stays 1.
REQ-024 Reset mid-stream: rst_i asserted with 2 slots full -> all outputs take their reset values. After release, rd_avail_o = 0 and wr_free_o = 4.
REQ-025 PROT_WR=0: write while full -> slot is overwritten, wr_err_o = 1, and the ready state inverts as specified in REQ-016.
